fc1_ofm_buffer: RTL

Output-feature-map buffer directly downstream of the FC1 control unit and datapath. Captures the NUM_NEURONS (84) FC1 results as FC1 writes them, then, once FC1 signals block completion, replays them one at a time to the FC2 stage with the same pulse-per-element start handshake that FC1 itself consumes. After FC2 has taken the whole block, it releases FC1 from its hold state through end_to_previous.

---
 rtl/fc1_ofm_buffer_pkg.sv | 16 +
 rtl/fc_buffer_ram.sv | 33 +++
 rtl/fc1_ofm_buffer.sv | 115 +++++++++++
 3 files changed

// File: rtl/fc1_ofm_buffer_pkg.sv
// Shared types for the FC1 output-feature-map buffer.
// State encoding and layer sizes used by the buffer and its bench.
package fc1_ofm_buffer_pkg;

  localparam int FC1_NEURONS = 84;
  localparam int FC2_NEURONS = 10;

  typedef enum logic [2:0] {
    S_FILL,
    S_RD,
    S_ISSUE,
    S_WAIT_END,
    S_RELEASE
  } buf_state_t;

endpackage

// File: rtl/fc_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// clk/reset, wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data (1-cycle latency).
module fc_buffer_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 84,
  parameter int ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fc1_ofm_buffer.sv
// Captures one FC1 output block, replays it to FC2 one element per pulse.
// Ports: FC1 side data_in/enable_write_previous/start_from_previous/end_to_previous,
// FC2 side data_out/start_to_next/end_from_next, sticky buffer_error.
module fc1_ofm_buffer
  import fc1_ofm_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_NEURONS = FC1_NEURONS,
  parameter int ADDR_BITS   = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enable_write_previous,
  input  logic                  start_from_previous,
  output logic                  end_to_previous,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  start_to_next,
  input  logic                  end_from_next,
  output logic                  buffer_error
);

  localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(NUM_NEURONS - 1);
  localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS + 1)'(NUM_NEURONS);

  buf_state_t           state;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   wr_cnt;
  logic                 wr_ok;
  logic [ADDR_BITS:0]   cnt_after;

  assign wr_ok = (state == S_FILL) && enable_write_previous
               && (wr_cnt != CNT_FULL);
  // Count including a write landing in the same cycle as the start pulse.
  assign cnt_after = wr_cnt + {{ADDR_BITS{1'b0}}, wr_ok};

  fc_buffer_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (NUM_NEURONS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_ok),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_en  (state == S_RD),
    .rd_addr(rd_ptr),
    .rd_data(data_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_FILL;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      wr_cnt          <= '0;
      start_to_next   <= 1'b0;
      end_to_previous <= 1'b0;
      buffer_error    <= 1'b0;
    end else begin
      start_to_next   <= 1'b0;
      end_to_previous <= 1'b0;

      if (wr_ok) begin
        wr_cnt <= cnt_after;
        if (wr_ptr != PTR_LAST)
          wr_ptr <= wr_ptr + 1'b1;
      end

      // Overflow writes and writes outside FILL are both dropped.
      if (enable_write_previous && !wr_ok)
        buffer_error <= 1'b1;
      if (start_from_previous && state != S_FILL)
        buffer_error <= 1'b1;

      unique case (state)
        S_FILL: begin
          if (start_from_previous) begin
            state <= S_RD;
            if (cnt_after != CNT_FULL)
              buffer_error <= 1'b1;
          end
        end
        S_RD: begin
          state         <= S_ISSUE;
          start_to_next <= 1'b1;
        end
        S_ISSUE: begin
          if (rd_ptr == PTR_LAST) begin
            rd_ptr <= '0;
            state  <= S_WAIT_END;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
            state  <= S_RD;
          end
        end
        S_WAIT_END: begin
          if (end_from_next) begin
            state           <= S_RELEASE;
            end_to_previous <= 1'b1;
          end
        end
        S_RELEASE: begin
          wr_ptr <= '0;
          wr_cnt <= '0;
          state  <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
